sampler_sample_reader: RTL and testbench

Consumer side of the sampler address path. On each audio sample tick it requests the next note address from the address-control block and reads one 16-bit sample from external SRAM at that address. It then presents the sample to the audio codec interface with a one-cycle valid strobe. It sits between the sampler address control, the SRAM pins and the codec serializer.

---
 rtl/sampler_pkg.sv | 18 +
 rtl/sampler_sample_reader_tick_sync.sv | 28 ++
 rtl/sampler_sample_reader.sv | 127 ++++++++++++
 tb/tb_sampler_sample_reader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared types and default widths for the sampler read path.
// Used by the sample reader and by the codec-side tick logic.
package sampler_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SETUP,
    WAIT,
    CAPTURE
  } reader_state_t;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

endpackage

// File: rtl/sampler_sample_reader_tick_sync.sv
// Two-flop synchronizer plus rising-edge detect for a slow async level.
// Emits a one-cycle tick; shared with the codec serializer side.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign tick = sync & ~sync_q;

endmodule

// File: rtl/sampler_sample_reader.sv
// Per sample tick: fetch a note address, read one SRAM word, strobe it out.
// Build option SAMPLER_VOLUME_EN adds a 4-bit volume scale on capture.
module sampler_sample_reader
  import sampler_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              sample_clk,
  output logic              addr_init,
  input  logic              addr_done,
  input  logic [ADDR_W-1:0] note_address,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              overrun,
  output logic              timeout_err
`ifdef SAMPLER_VOLUME_EN
  ,
  input  logic [3:0]        volume
`endif
);

  localparam logic [9:0] TOUT_LAST = 10'(TIMEOUT - 1);
  localparam logic [9:0] WAIT_LAST = 10'(WAIT_CYCLES - 1);

  reader_state_t state;
  reader_state_t state_d;
  logic [9:0]    cnt;
  logic [9:0]    cnt_d;
  logic          tick;
  logic          load_addr;
  logic          do_cap;
  logic          do_tout;
  logic [DATA_W-1:0] cap_data;

  tick_sync u_tick_sync (
    .clk      (Clk),
    .rst_n    (Reset),
    .async_in (sample_clk),
    .tick     (tick)
  );

`ifdef SAMPLER_VOLUME_EN
  logic signed [DATA_W+4:0] prod;
  assign prod = (DATA_W+5)'($signed(SRAM_DQ))
              * (DATA_W+5)'($signed({1'b0, volume}));
  assign cap_data = DATA_W'(prod >>> 4);
`else
  assign cap_data = SRAM_DQ;
`endif

  always_comb begin
    state_d   = state;
    addr_init = 1'b0;
    load_addr = 1'b0;
    do_cap    = 1'b0;
    do_tout   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) state_d = REQ;
      end
      REQ: begin
        addr_init = (cnt == 10'd0);
        if (addr_done) begin
          load_addr = 1'b1;
          state_d   = SETUP;
        end else if (cnt == TOUT_LAST) begin
          do_tout = 1'b1;
          state_d = IDLE;
        end
      end
      SETUP: state_d = WAIT;
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          do_cap  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One counter serves both the REQ timeout and the WAIT states
  assign cnt_d     = (state_d == state) ? cnt + 10'd1 : 10'd0;
  assign SRAM_CE_N = !((state == SETUP) || (state == WAIT));
  assign SRAM_OE_N = SRAM_CE_N;
  assign SRAM_WE_N = 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt          <= '0;
      SRAM_ADDR    <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      sample_valid <= do_cap | do_tout;
      if (load_addr) SRAM_ADDR <= note_address;
      if (do_cap) sample_out <= cap_data;
      else if (do_tout) sample_out <= '0;
      if (do_tout) timeout_err <= 1'b1;
      // Ticks outside IDLE are dropped, including the return-to-IDLE cycle
      if (tick && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sampler_sample_reader.sv
// Randomized bench for sampler_sample_reader with SRAM and address models.
// Define SAMPLER_VOLUME_EN to also exercise the volume build.
module tb_sampler_sample_reader;

  logic        Clk;
  logic        Reset;
  logic        sample_clk;
  logic        addr_init;
  logic        addr_done;
  logic [19:0] note_address;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        overrun;
  logic        timeout_err;
  logic [3:0]  volume;

  sampler_sample_reader dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .sample_clk   (sample_clk),
    .addr_init    (addr_init),
    .addr_done    (addr_done),
    .note_address (note_address),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_DQ      (SRAM_DQ),
    .SRAM_CE_N    (SRAM_CE_N),
    .SRAM_OE_N    (SRAM_OE_N),
    .SRAM_WE_N    (SRAM_WE_N),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
`ifdef SAMPLER_VOLUME_EN
    ,
    .volume       (volume)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_init   = 0;
  int n_ce     = 0;
  int init_cyc = 0;
  int valid_cyc = 0;
  int tout_cyc = 0;
  logic tout_q = 1'b0;

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];

  logic        resp_en;
  logic        rand_addr;
  int          dly_min;
  int          dly_max;
  logic [19:0] fixed_addr;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t over limit 2000000", $time);
    $fatal(1);
  end

  always @(posedge Clk) cyc <= cyc + 1;

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]]
                                             : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected capture value from the spec's gain rule
  function automatic logic [15:0] scale(input logic [15:0] d);
`ifdef SAMPLER_VOLUME_EN
    int p;
    p = int'($signed(d)) * int'(volume);
    return 16'(p >>> 4);
`else
    return d;
`endif
  endfunction

  always @(negedge Clk) begin
    logic [15:0] e;
    if (addr_init) begin
      n_init++;
      init_cyc = cyc;
    end
    if (!SRAM_CE_N) n_ce++;
    if (timeout_err && !tout_q) tout_cyc = cyc;
    tout_q = timeout_err;
    if (sample_valid) begin
      n_valid++;
      valid_cyc = cyc;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
      check("sample", {16'h0, sample_out}, {16'h0, e});
    end
  end

  initial begin : addr_ctl
    int d;
    logic [19:0] a;
    forever begin
      @(posedge Clk);
      #1;
      if (addr_init && resp_en) begin
        d = $urandom_range(dly_max, dly_min);
        repeat (d) begin
          @(posedge Clk);
          #1;
        end
        a = rand_addr ? 20'($urandom) : fixed_addr;
        note_address = a;
        addr_done = 1'b1;
        exp_q.push_back(scale(mem[a[7:0]]));
        @(posedge Clk);
        #1;
        addr_done = 1'b0;
      end
    end
  end

  task automatic rise_clk();
    sample_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    sample_clk = 1'b1;
  endtask

  task automatic wait_init(input int budget);
    int n = 0;
    while (!addr_init && n < budget) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("init_wait", {31'h0, addr_init}, 32'h1);
  endtask

  task automatic wait_valids(input int target, input int budget);
    int n = 0;
    while (n_valid < target && n < budget) begin
      @(posedge Clk);
      n++;
    end
    check("valid_wait", {31'h0, n_valid >= target}, 32'h1);
  endtask

  task automatic pulse_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    exp_q.delete();
  endtask

  initial begin : main
    int v0;
    int i0;
    int c0;
    logic [15:0] e;
    Reset = 1'b0;
    sample_clk = 1'b0;
    addr_done = 1'b0;
    note_address = '0;
    volume = 4'd15;
    resp_en = 1'b1;
    rand_addr = 1'b0;
    dly_min = 0;
    dly_max = 0;
    fixed_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge Clk);
    #1;
    check("rst_init", {31'h0, addr_init}, 32'h0);
    check("rst_addr", {12'h0, SRAM_ADDR}, 32'h0);
    check("rst_ce", {31'h0, SRAM_CE_N}, 32'h1);
    check("rst_oe", {31'h0, SRAM_OE_N}, 32'h1);
    check("rst_we", {31'h0, SRAM_WE_N}, 32'h1);
    check("rst_out", {16'h0, sample_out}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_ovr", {31'h0, overrun}, 32'h0);
    check("rst_tout", {31'h0, timeout_err}, 32'h0);
    Reset = 1'b1;

    // basic read, addr_done one cycle after addr_init
    mem[8'h34] = 16'hBEEF;
    fixed_addr = 20'h01234;
    dly_min = 1;
    dly_max = 1;
    v0 = n_valid; i0 = n_init; c0 = n_ce;
    rise_clk();
    wait_valids(v0 + 1, 60);
    repeat (5) @(posedge Clk);
    #1;
    check("rd_addr", {12'h0, SRAM_ADDR}, 32'h01234);
    check("rd_ce_cycles", n_ce - c0, 3);
    check("rd_latency", valid_cyc - init_cyc, 5);
    check("rd_nvalid", n_valid - v0, 1);
    check("rd_ninit", n_init - i0, 1);
    check("rd_data", {16'h0, sample_out}, {16'h0, scale(16'hBEEF)});

    // address control never answers
    resp_en = 1'b0;
    v0 = n_valid; i0 = n_init; c0 = n_ce;
    rise_clk();
    wait_init(20);
    repeat (300) @(posedge Clk);
    #1;
    check("to_flag", {31'h0, timeout_err}, 32'h1);
    check("to_cycles", tout_cyc - init_cyc, 255);
    check("to_nvalid", n_valid - v0, 1);
    check("to_valid_cyc", valid_cyc, tout_cyc);
    check("to_out", {16'h0, sample_out}, 32'h0);
    check("to_ninit", n_init - i0, 1);
    check("to_ce", n_ce - c0, 0);
    check("to_ovr", {31'h0, overrun}, 32'h0);
    resp_en = 1'b1;

    // second edge lands while the first access is in WAIT
    pulse_reset();
    dly_min = 0;
    dly_max = 0;
    fixed_addr = 20'hABC55;
    v0 = n_valid; i0 = n_init;
    sample_clk = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    sample_clk = 1'b1;
    @(posedge Clk);
    #3;
    sample_clk = 1'b0;
    wait_init(20);
    sample_clk = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    check("ov_flag", {31'h0, overrun}, 32'h1);
    check("ov_nvalid", n_valid - v0, 1);
    check("ov_ninit", n_init - i0, 1);
    check("ov_data", {16'h0, sample_out}, {16'h0, scale(mem[8'h55])});
    check("ov_tout", {31'h0, timeout_err}, 32'h0);

    // reset while the SRAM access is in WAIT
    fixed_addr = 20'h00777;
    v0 = n_valid;
    rise_clk();
    wait_init(20);
    sample_clk = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      #1;
    end
    check("mr_ce_wait", {31'h0, SRAM_CE_N}, 32'h0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("mr_ce", {31'h0, SRAM_CE_N}, 32'h1);
    check("mr_oe", {31'h0, SRAM_OE_N}, 32'h1);
    check("mr_valid", {31'h0, sample_valid}, 32'h0);
    check("mr_out", {16'h0, sample_out}, 32'h0);
    check("mr_ovr", {31'h0, overrun}, 32'h0);
    Reset = 1'b1;
    exp_q.delete();
    repeat (10) @(posedge Clk);
    #1;
    check("mr_nvalid", n_valid - v0, 0);
    v0 = n_valid;
    rise_clk();
    wait_valids(v0 + 1, 60);
    repeat (3) @(posedge Clk);
    #1;
    check("mr_next", {16'h0, sample_out}, {16'h0, scale(mem[8'h77])});

`ifdef SAMPLER_VOLUME_EN
    mem[8'h21] = 16'h8000;
    fixed_addr = 20'h00021;
    volume = 4'd8;
    v0 = n_valid;
    rise_clk();
    wait_valids(v0 + 1, 60);
    #1;
    check("vol8", {16'h0, sample_out}, 32'h0000C000);
    volume = 4'd0;
    rise_clk();
    wait_valids(v0 + 2, 60);
    #1;
    check("vol0", {16'h0, sample_out}, 32'h0);
    volume = 4'($urandom_range(15, 0));
`endif

    // free-running ticks with random addresses and answer delays
    pulse_reset();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rand_addr = 1'b1;
    dly_min = 0;
    dly_max = 20;
    sample_clk = 1'b0;
    repeat (4) @(posedge Clk);
    v0 = n_valid;
    for (int k = 0; k < 400; k++) begin
      sample_clk = 1'b1;
      #(200 + $urandom_range(90, 0));
      sample_clk = 1'b0;
      #(300 + $urandom_range(90, 0));
    end
    repeat (80) @(posedge Clk);
    #1;
    check("rnd_nvalid", n_valid - v0, 400);
    check("rnd_ovr", {31'h0, overrun}, 32'h0);
    check("rnd_tout", {31'h0, timeout_err}, 32'h0);
    check("rnd_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
